// File: rtl/mat_pkg.sv
// Shared constants and types for the result-matrix readout path.
// Elements are stored with their row/col/last tags so the stream stays self-describing.
package mat_pkg;
   localparam int DATA_W = 19;
   localparam int DIM    = 8;
   localparam int ADDR_W = 6;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } rd_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [IDX_W-1:0]  row;
      logic [IDX_W-1:0]  col;
      logic              last_row;
      logic              last;
   } elem_t;

   function automatic logic [ADDR_W-1:0] elem_addr(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
      return {row, col};
   endfunction
endpackage

// File: rtl/elem_fifo2.sv
// Two-entry shift FIFO: slot 0 is always the head, so the head is a plain register.
// A vacated slot is zeroed, which keeps the stream outputs at zero while empty.
module elem_fifo2
   import mat_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  elem_t      i_din,
   input  logic       i_pop,
   output elem_t      o_head,
   output logic [1:0] o_count
);
   elem_t      r_slot0;
   elem_t      r_slot1;
   logic [1:0] r_count;

   // Storage and occupancy update; the parent never pushes when full or pops when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot0 <= '0;
         r_slot1 <= '0;
         r_count <= 2'd0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_count == 2'd0) r_slot0 <= i_din;
               else                 r_slot1 <= i_din;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_slot0 <= r_slot1;
               r_slot1 <= '0;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_slot0 <= i_din;
               end else begin
                  r_slot0 <= r_slot1;
                  r_slot1 <= i_din;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_head  = r_slot0;
   assign o_count = r_count;
endmodule

// File: rtl/matrix_result_reader.sv
// Walks the 8x8 result RAM in row- or column-major order and streams each element
// with row/col/last tags; a 2-entry buffer plus one in-flight read absorbs RAM latency.
module matrix_result_reader
   import mat_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              col_major,
   output logic              busy,
   output logic              done,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [IDX_W-1:0]  m_row,
   output logic [IDX_W-1:0]  m_col,
   output logic              m_last_row,
   output logic              m_last
);
   rd_state_t        r_state;
   rd_state_t        w_next_state;
   logic [5:0]       r_n;
   logic             r_col_major;
   logic             r_inflight;
   logic [IDX_W-1:0] r_tag_row;
   logic [IDX_W-1:0] r_tag_col;
   logic             r_tag_last_row;
   logic             r_tag_last;

   logic [IDX_W-1:0] w_row;
   logic [IDX_W-1:0] w_col;
   logic             w_issue;
   logic             w_credit_ok;
   logic             w_pop;
   logic [1:0]       w_count;
   elem_t            w_head;
   elem_t            w_din;

   assign w_row = r_col_major ? r_n[2:0] : r_n[5:3];
   assign w_col = r_col_major ? r_n[5:3] : r_n[2:0];

   assign m_valid = (w_count != 2'd0);
   assign w_pop   = m_valid & m_ready;
   // Occupancy after this cycle's pop, counting the read already in flight, must leave room.
   assign w_credit_ok = (({1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);

   // Next-state and read-issue decode.
   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next_state = ISSUE;
            else       w_next_state = IDLE;
         end
         ISSUE: begin
            w_issue = w_credit_ok;
            if (w_credit_ok && (r_n == 6'd63)) w_next_state = DRAIN;
            else                               w_next_state = ISSUE;
         end
         DRAIN: begin
            if (w_pop && w_head.last) w_next_state = FIN;
            else                      w_next_state = DRAIN;
         end
         FIN:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State, issue counter, order latch and the tag riding with the in-flight read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_n            <= 6'd0;
         r_col_major    <= 1'b0;
         r_inflight     <= 1'b0;
         r_tag_row      <= '0;
         r_tag_col      <= '0;
         r_tag_last_row <= 1'b0;
         r_tag_last     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_inflight <= w_issue;
         if ((r_state == IDLE) && start) begin
            r_col_major <= col_major;
            r_n         <= 6'd0;
         end else if (w_issue) begin
            r_n <= r_n + 6'd1;
         end
         if (w_issue) begin
            r_tag_row      <= w_row;
            r_tag_col      <= w_col;
            r_tag_last_row <= (r_n[2:0] == IDX_W'(DIM - 1));
            r_tag_last     <= (r_n == 6'd63);
         end
      end
   end

   assign w_din = '{data: ram_rd_data, row: r_tag_row, col: r_tag_col,
                    last_row: r_tag_last_row, last: r_tag_last};

   elem_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (r_inflight),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign busy        = (r_state == ISSUE) || (r_state == DRAIN);
   assign done        = (r_state == FIN);
   assign ram_rd_en   = w_issue;
   assign ram_rd_addr = elem_addr(w_row, w_col);
   assign m_data      = w_head.data;
   assign m_row       = w_head.row;
   assign m_col       = w_head.col;
   assign m_last_row  = w_head.last_row;
   assign m_last      = w_head.last;
endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed/randomized bench for matrix_result_reader with a behavioural RAM and
// an order model that derives every expected element from its sequence index.
module tb_matrix_result_reader;
   import mat_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              col_major;
   logic              busy;
   logic              done;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data = '0;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic [IDX_W-1:0]  m_row;
   logic [IDX_W-1:0]  m_col;
   logic              m_last_row;
   logic              m_last;

   logic [DATA_W-1:0] ram [0:63];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
   end

   matrix_result_reader dut (
      .clk(clk), .rst(rst), .start(start), .col_major(col_major),
      .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
      .ram_rd_data(ram_rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_row(m_row), .m_col(m_col), .m_last_row(m_last_row), .m_last(m_last)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},     32'(busy),        32'd0);
      check({tag, "_done"},     32'(done),        32'd0);
      check({tag, "_rd_en"},    32'(ram_rd_en),   32'd0);
      check({tag, "_addr"},     32'(ram_rd_addr), 32'd0);
      check({tag, "_valid"},    32'(m_valid),     32'd0);
      check({tag, "_data"},     32'(m_data),      32'd0);
      check({tag, "_row"},      32'(m_row),       32'd0);
      check({tag, "_col"},      32'(m_col),       32'd0);
      check({tag, "_last_row"}, 32'(m_last_row),  32'd0);
      check({tag, "_last"},     32'(m_last),      32'd0);
   endtask

   // Sequence index n -> matrix coordinates for the selected order.
   function automatic void model_rc(input bit cm, input int n, output int r, output int c);
      if (cm) begin c = n / 8; r = n % 8; end
      else    begin r = n / 8; c = n % 8; end
   endfunction

   // pat: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
   task automatic run_readout(input bit cm, input int pat, input int restart_at, input int abort_at);
      int issued, got, hs, r, c, idx;
      bit finished, aborted, restarted, prev_stall;
      logic [DATA_W-1:0] held_d;
      logic [IDX_W-1:0]  held_r, held_c;
      issued = 0; got = 0; finished = 0; aborted = 0; restarted = 0; prev_stall = 0;
      held_d = '0; held_r = '0; held_c = '0;
      @(negedge clk);
      start = 1'b1; col_major = cm; m_ready = 1'b0;
      for (int k = 1; k <= 600 && !finished && !aborted; k++) begin
         @(negedge clk);
         start = 1'b0; col_major = cm;
         if (restart_at >= 0 && !restarted && got == restart_at) begin
            start = 1'b1; col_major = ~cm; restarted = 1'b1;
         end
         idx = (k - 1) % 4;
         case (pat)
            0:       m_ready = 1'b1;
            1:       m_ready = (idx == 0) || (idx == 3);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (k == 1) check("first_rd_en", 32'(ram_rd_en), 32'd1);
         if (k == 2) check("no_early_valid", 32'(m_valid), 32'd0);
         if (k == 3) check("valid_at_T3", 32'(m_valid), 32'd1);
         if (prev_stall) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(held_d));
            check("stall_row", 32'(m_row), 32'(held_r));
            check("stall_col", 32'(m_col), 32'(held_c));
         end
         hs = (m_valid && m_ready) ? 1 : 0;
         if (ram_rd_en) begin
            check("credit", 32'((issued - got - hs) < 2), 32'd1);
            check("rd_count", 32'(issued < 64), 32'd1);
            model_rc(cm, issued, r, c);
            check("rd_addr", 32'(ram_rd_addr), 32'(r * 8 + c));
            issued++;
         end
         if (hs == 1) begin
            model_rc(cm, got, r, c);
            check("data", 32'(m_data), 32'(ram[r * 8 + c]));
            check("row", 32'(m_row), 32'(r));
            check("col", 32'(m_col), 32'(c));
            check("last_row", 32'(m_last_row), 32'(got % 8 == 7));
            check("last", 32'(m_last), 32'(got == 63));
            got++;
         end
         if (done) begin
            check("done_after_all", 32'(got), 32'd64);
            if (pat == 0) check("done_cycle", 32'(k), 32'd67);
            finished = 1'b1;
         end else begin
            check("busy_during", 32'(busy), 32'd1);
         end
         if (abort_at >= 0 && got == abort_at) aborted = 1'b1;
         prev_stall = m_valid && !m_ready;
         held_d = m_data; held_r = m_row; held_c = m_col;
      end
      start = 1'b0;
      if (aborted) begin
         @(negedge clk);
         rst = 1'b0;
         #1;
         check_zero("abort");
         repeat (3) begin
            @(negedge clk);
            #1;
            check("abort_no_done", 32'(done), 32'd0);
         end
         rst = 1'b1;
      end else if (!finished) begin
         check("timeout", 32'd0, 32'd1);
      end else begin
         repeat (4) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            check("post_done", 32'(done), 32'd0);
            check("post_busy", 32'(busy), 32'd0);
            check("post_valid", 32'(m_valid), 32'd0);
         end
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; col_major = 1'b0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_zero("reset");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; rst = 1'b1;
      @(negedge clk);
      #1;
      check("start_in_reset_busy", 32'(busy), 32'd0);
      check("start_in_reset_rd_en", 32'(ram_rd_en), 32'd0);

      for (int a = 0; a < 64; a++) ram[a] = DATA_W'(a);
      run_readout(1'b0, 0, -1, -1);
      run_readout(1'b1, 0, -1, -1);

      for (int a = 0; a < 64; a++) ram[a] = DATA_W'($urandom);
      ram[0] = 19'h7FFFF; ram[1] = 19'h40000; ram[2] = 19'h3FFFF;
      run_readout(1'b0, 0, -1, -1);
      run_readout(1'b0, 1, -1, -1);
      run_readout(1'b1, 2, -1, -1);
      run_readout(1'b0, 0, 20, -1);
      run_readout(1'b1, 0, 20, -1);
      run_readout(1'b0, 2, -1, 31);
      run_readout(1'b1, 1, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/matrix_result_reader.md
Name: matrix_result_reader

Overview:
Reader side of the 8x8 result-matrix RAM written by the 4-lane MAC array. It walks all 64 signed 19-bit C elements in row-major or column-major order and issues synchronous RAM reads with 1-cycle latency. Elements are presented on a valid/ready output stream, with row/col tags and end-of-row/end-of-matrix markers. A 2-entry buffer absorbs RAM latency under backpressure, so no element is dropped or duplicated.

Parameters:
DATA_W, 19, element width (signed two's complement, matches MAC accumulator)
DIM, 8, matrix dimension (square)
ADDR_W, 6, RAM address width, log2(DIM*DIM)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle request to begin a readout; ignored while busy
col_major  in  1  order select, sampled with start: 0 row-major, 1 column-major
busy  out  1  high from cycle after accepted start until done pulse
done  out  1  one-cycle pulse after final element handshake
ram_rd_en  out  1  RAM read strobe
ram_rd_addr  out  ADDR_W  element address = row*DIM + col
ram_rd_data  in  DATA_W  RAM data, valid the cycle after ram_rd_en
m_data  out  DATA_W  element value
m_valid  out  1  element present
m_ready  in  1  consumer accepts when m_valid & m_ready
m_row  out  3  row index of m_data
m_col  out  3  column index of m_data
m_last_row  out  1  last element of current row (row-major) / column (column-major)
m_last  out  1  element 63 of the sequence

Behaviour:
- Reset (rst=0, any time, incl. mid-readout): FSM->IDLE, counters/buffer cleared. busy, done, ram_rd_en, m_valid, m_last, m_last_row = 0; ram_rd_addr, m_data, m_row, m_col = 0. Abort is silent: no done pulse.
- FSM states: IDLE -> ISSUE on start. ISSUE -> DRAIN after 64th read issued. DRAIN -> FIN when buffer is empty and the 64th handshake occurs. FIN (done=1 for one cycle) -> IDLE.
- Issue index n runs 0..63. Row-major: row=n/8, col=n%8. Column-major: col=n/8, row=n%8. Address is always row*8+col.
- Read issued only if (buffer_count + inflight - pop_this_cycle) < 2. Inflight is 0 or 1. This gives sustained 1 element/cycle with m_ready held high and never overflows the buffer.
- Row/col/last tags travel with each read through an inflight tag register and are stored alongside data in the buffer.
- Latency: start sampled at edge T -> ram_rd_en=1, addr for n=0 during cycle T+1 -> m_valid=1 in cycle T+3.
- Throughput: with m_ready=1 throughout, last handshake in cycle T+66 and done in cycle T+67. Total 67 cycles start-to-done.
- Stream rules:
  - m_data and tags are held stable while m_valid & !m_ready.
  - m_valid never drops without a handshake.
  - Element order is strictly n order.
- Sign: m_data is a bit-exact copy of the RAM word, with no extension or truncation.
- start while busy or in FIN: ignored, and col_major is not resampled.
- start coincident with rst=0: reset wins.
- m_ready may be high while m_valid=0; this has no effect.

Decomposition:
- Package mat_pkg: DATA_W=19, DIM=8, ADDR_W=6, IDX_W=3, rd_state_t enum {IDLE, ISSUE, DRAIN, FIN}, packed elem_t {data, row, col, last_row, last}.
- One sub-module: elem_fifo2, a 2-entry FIFO of elem_t with push/pop/count and async active-low reset. The credit check lives in the parent.

Test Plan:
1. RAM[a]=a, col_major=0, m_ready=1, start at edge T -> m_valid in cycle T+3. Stream emits 0,1,2..63. m_last_row on 7,15,..,63. m_last only on 63. done pulses in cycle T+67.
2. Same RAM, col_major=1 -> m_data sequence 0,8,16..56,1,9..63. (m_row,m_col) of the 2nd element = (1,0). m_last_row on 56,57,..,63.
3. Signed extremes RAM[0]=19'h7FFFF (-1), RAM[1]=19'h40000, RAM[2]=19'h3FFFF -> exact same bit patterns out.
4. Backpressure: m_ready toggles 1,0,0,1 repeating -> all 64 elements exactly once, in order, and data is stable during stalls. ram_rd_en is never high when buffer_count+inflight would exceed 2.
5. start pulsed again at element 20 with col_major flipped -> ignored: order unchanged, one done pulse only.
6. rst=0 asserted after element 30 handshake -> all outputs 0 immediately with no done pulse. Release, then start -> clean readout from element 0.
